// File: rtl/jtag_dtm_pkg.sv
// Shared types and constants for the JTAG debug transport module.
// Macro JTAG_DTM_IDCODE_EN adds the IDCODE register and makes it the reset instruction.
package jtag_dtm_pkg;

   typedef enum logic [3:0] {
      TAP_RESET,
      TAP_IDLE,
      TAP_SELECT_DR,
      TAP_CAPTURE_DR,
      TAP_SHIFT_DR,
      TAP_EXIT1_DR,
      TAP_PAUSE_DR,
      TAP_EXIT2_DR,
      TAP_UPDATE_DR,
      TAP_SELECT_IR,
      TAP_CAPTURE_IR,
      TAP_SHIFT_IR,
      TAP_EXIT1_IR,
      TAP_PAUSE_IR,
      TAP_EXIT2_IR,
      TAP_UPDATE_IR
   } tap_state_e;

   typedef enum logic [1:0] {
      DR_BYPASS,
      DR_IDCODE,
      DR_DTMCS,
      DR_DMI
   } dr_sel_e;

   localparam logic [4:0] IR_IDCODE  = 5'h01;
   localparam logic [4:0] IR_DTMCS   = 5'h10;
   localparam logic [4:0] IR_DMI     = 5'h11;
   localparam logic [4:0] IR_BYPASS  = 5'h1F;
   localparam logic [4:0] IR_CAPTURE = 5'b00001;

`ifdef JTAG_DTM_IDCODE_EN
   localparam logic [4:0] IR_RESET = IR_IDCODE;
`else
   localparam logic [4:0] IR_RESET = IR_BYPASS;
`endif

   localparam logic [1:0] DMI_OP_READ  = 2'd1;
   localparam logic [1:0] DMI_OP_WRITE = 2'd2;

   localparam logic [1:0] DMISTAT_OK     = 2'd0;
   localparam logic [1:0] DMISTAT_FAILED = 2'd2;
   localparam logic [1:0] DMISTAT_BUSY   = 2'd3;

   localparam logic [3:0] DTMCS_VERSION = 4'd1;
   localparam logic [2:0] DTMCS_IDLE    = 3'd1;

   // Unknown opcodes fall back to BYPASS.
   function automatic dr_sel_e decode_ir(input logic [4:0] ir);
      case (ir)
`ifdef JTAG_DTM_IDCODE_EN
         IR_IDCODE: decode_ir = DR_IDCODE;
`endif
         IR_DTMCS:  decode_ir = DR_DTMCS;
         IR_DMI:    decode_ir = DR_DMI;
         default:   decode_ir = DR_BYPASS;
      endcase
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller advanced by synchronized TCK rise strobes.
// Each strobe fires on the TCK rise taken while sitting in its state.
module jtag_tap_fsm
   import jtag_dtm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       tck_rise,
   input  logic       tms,
   output tap_state_e state,
   output logic       capture_dr,
   output logic       shift_dr,
   output logic       update_dr,
   output logic       capture_ir,
   output logic       shift_ir,
   output logic       update_ir
);

   tap_state_e state_q, state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= TAP_RESET;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      capture_dr = 1'b0;
      shift_dr   = 1'b0;
      update_dr  = 1'b0;
      capture_ir = 1'b0;
      shift_ir   = 1'b0;
      update_ir  = 1'b0;
      if (tck_rise) begin
         capture_dr = (state_q == TAP_CAPTURE_DR);
         shift_dr   = (state_q == TAP_SHIFT_DR);
         update_dr  = (state_q == TAP_UPDATE_DR);
         capture_ir = (state_q == TAP_CAPTURE_IR);
         shift_ir   = (state_q == TAP_SHIFT_IR);
         update_ir  = (state_q == TAP_UPDATE_IR);
         case (state_q)
            TAP_RESET:      state_d = tms ? TAP_RESET     : TAP_IDLE;
            TAP_IDLE:       state_d = tms ? TAP_SELECT_DR : TAP_IDLE;
            TAP_SELECT_DR:  state_d = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   state_d = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   state_d = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   state_d = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   state_d = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  state_d = tms ? TAP_SELECT_DR : TAP_IDLE;
            TAP_SELECT_IR:  state_d = tms ? TAP_RESET     : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   state_d = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   state_d = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   state_d = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   state_d = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  state_d = tms ? TAP_SELECT_DR : TAP_IDLE;
            default:        state_d = TAP_RESET;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: rtl/jtag_dtm.sv
// JTAG debug transport: oversampled TAP, IR/DR chains, and a single-outstanding DMI master.
// Macro JTAG_DTM_IDCODE_EN enables the IDCODE data register.
module jtag_dtm
   import jtag_dtm_pkg::*;
#(
   parameter logic [31:0] IDCODE_VALUE = 32'h1E20_0A6D,
   parameter int unsigned ABITS        = 7,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tck_i,
   input  logic             tms_i,
   input  logic             tdi_i,
   output logic             tdo_o,
   output logic             tdo_oe_o,
   output logic             dmi_req_valid_o,
   input  logic             dmi_req_ready_i,
   output logic [ABITS-1:0] dmi_req_addr_o,
   output logic [1:0]       dmi_req_op_o,
   output logic [31:0]      dmi_req_data_o,
   input  logic             dmi_resp_valid_i,
   output logic             dmi_resp_ready_o,
   input  logic [31:0]      dmi_resp_data_i,
   input  logic [1:0]       dmi_resp_op_i
);

   localparam int unsigned DMI_W       = ABITS + 34;
   localparam logic [5:0]  ABITS_FIELD = 6'(ABITS);

   // ---------------- pin synchronizers and edge strobes ----------------
   logic [2:0] sync_q [SYNC_STAGES];
   logic       tck_s, tck_prev_q, tck_rise_q, tck_fall_q, tms_q, tdi_q;

   assign tck_s = sync_q[SYNC_STAGES-1][2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         tck_prev_q <= 1'b0;
         tck_rise_q <= 1'b0;
         tck_fall_q <= 1'b0;
         tms_q      <= 1'b0;
         tdi_q      <= 1'b0;
      end else begin
         sync_q[0] <= {tck_i, tms_i, tdi_i};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         tck_prev_q <= tck_s;
         tck_rise_q <= tck_s & ~tck_prev_q;
         tck_fall_q <= ~tck_s & tck_prev_q;
         tms_q      <= sync_q[SYNC_STAGES-1][1];
         tdi_q      <= sync_q[SYNC_STAGES-1][0];
      end
   end

   // ---------------- TAP controller ----------------
   tap_state_e tap_state;
   logic       capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

   jtag_tap_fsm u_tap (
      .clk        (clk),
      .reset      (reset),
      .tck_rise   (tck_rise_q),
      .tms        (tms_q),
      .state      (tap_state),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir)
   );

   // ---------------- instruction register ----------------
   logic [4:0] ir_sr_q, ir_q;
   dr_sel_e    dr_sel;

   assign dr_sel = decode_ir(ir_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_sr_q <= '0;
         ir_q    <= IR_RESET;
      end else begin
         if (capture_ir)    ir_sr_q <= IR_CAPTURE;
         else if (shift_ir) ir_sr_q <= {tdi_q, ir_sr_q[4:1]};
         if (tap_state == TAP_RESET) ir_q <= IR_RESET;
         else if (update_ir)         ir_q <= ir_sr_q;
      end
   end

   // ---------------- DMI bookkeeping signals ----------------
   logic             req_valid_q, outstanding_q;
   logic [ABITS-1:0] req_addr_q, last_addr_q;
   logic [31:0]      req_data_q, resp_data_q;
   logic [1:0]       req_op_q, dmistat_q;
   logic             busy_eff;
   logic [1:0]       stat_eff;

   // A response in the same clk is applied before any capture/update looks at state.
   always_comb begin
      busy_eff = outstanding_q & ~dmi_resp_valid_i;
      stat_eff = dmistat_q;
      if (dmi_resp_valid_i && dmi_resp_op_i != 2'd0 && dmistat_q == DMISTAT_OK)
         stat_eff = DMISTAT_FAILED;
   end

   // ---------------- data registers ----------------
   logic             bypass_q;
   logic [31:0]      dtmcs_sr_q;
   logic [DMI_W-1:0] dmi_sr_q;
`ifdef JTAG_DTM_IDCODE_EN
   logic [31:0]      idcode_sr_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bypass_q    <= 1'b0;
         dtmcs_sr_q  <= '0;
         dmi_sr_q    <= '0;
`ifdef JTAG_DTM_IDCODE_EN
         idcode_sr_q <= '0;
`endif
      end else if (capture_dr) begin
         case (dr_sel)
`ifdef JTAG_DTM_IDCODE_EN
            DR_IDCODE: idcode_sr_q <= IDCODE_VALUE;
`endif
            DR_DTMCS:  dtmcs_sr_q  <= {14'b0, 2'b0, 1'b0, DTMCS_IDLE, dmistat_q,
                                       ABITS_FIELD, DTMCS_VERSION};
            DR_DMI:    dmi_sr_q    <= {last_addr_q, resp_data_q,
                                       busy_eff ? DMISTAT_BUSY : stat_eff};
            default:   bypass_q    <= 1'b0;
         endcase
      end else if (shift_dr) begin
         case (dr_sel)
`ifdef JTAG_DTM_IDCODE_EN
            DR_IDCODE: idcode_sr_q <= {tdi_q, idcode_sr_q[31:1]};
`endif
            DR_DTMCS:  dtmcs_sr_q  <= {tdi_q, dtmcs_sr_q[31:1]};
            DR_DMI:    dmi_sr_q    <= {tdi_q, dmi_sr_q[DMI_W-1:1]};
            default:   bypass_q    <= tdi_q;
         endcase
      end
   end

   // ---------------- TDO, launched on TCK fall ----------------
   logic dr_lsb;

   always_comb begin
      dr_lsb = bypass_q;
      case (dr_sel)
`ifdef JTAG_DTM_IDCODE_EN
         DR_IDCODE: dr_lsb = idcode_sr_q[0];
`endif
         DR_DTMCS:  dr_lsb = dtmcs_sr_q[0];
         DR_DMI:    dr_lsb = dmi_sr_q[0];
         default:   dr_lsb = bypass_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tdo_o    <= 1'b0;
         tdo_oe_o <= 1'b0;
      end else if (tck_fall_q) begin
         tdo_oe_o <= (tap_state == TAP_SHIFT_IR) || (tap_state == TAP_SHIFT_DR);
         if (tap_state == TAP_SHIFT_IR)      tdo_o <= ir_sr_q[0];
         else if (tap_state == TAP_SHIFT_DR) tdo_o <= dr_lsb;
         else                                tdo_o <= 1'b0;
      end
   end

   // ---------------- DMI request/response ----------------
   logic [ABITS-1:0] upd_addr;
   logic [31:0]      upd_data;
   logic [1:0]       upd_op;

   assign upd_addr = dmi_sr_q[DMI_W-1 -: ABITS];
   assign upd_data = dmi_sr_q[33:2];
   assign upd_op   = dmi_sr_q[1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_valid_q   <= 1'b0;
         req_addr_q    <= '0;
         req_data_q    <= '0;
         req_op_q      <= '0;
         outstanding_q <= 1'b0;
         dmistat_q     <= DMISTAT_OK;
         last_addr_q   <= '0;
         resp_data_q   <= '0;
      end else begin
         outstanding_q <= busy_eff;
         dmistat_q     <= stat_eff;
         if (dmi_resp_valid_i) resp_data_q <= dmi_resp_data_i;
         if (req_valid_q && dmi_req_ready_i) req_valid_q <= 1'b0;

         if (capture_dr && dr_sel == DR_DMI && busy_eff) dmistat_q <= DMISTAT_BUSY;

         if (update_dr && dr_sel == DR_DTMCS) begin
            if (dtmcs_sr_q[16] || dtmcs_sr_q[17]) dmistat_q <= DMISTAT_OK;
            if (dtmcs_sr_q[17]) begin
               outstanding_q <= 1'b0;
               req_valid_q   <= 1'b0;
            end
         end

         if (update_dr && dr_sel == DR_DMI &&
             (upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE)) begin
            if (busy_eff) begin
               dmistat_q <= DMISTAT_BUSY;
            end else if (stat_eff == DMISTAT_OK) begin
               req_valid_q   <= 1'b1;
               req_addr_q    <= upd_addr;
               req_data_q    <= upd_data;
               req_op_q      <= upd_op;
               last_addr_q   <= upd_addr;
               outstanding_q <= 1'b1;
            end
         end
      end
   end

   assign dmi_req_valid_o  = req_valid_q;
   assign dmi_req_addr_o   = req_addr_q;
   assign dmi_req_data_o   = req_data_q;
   assign dmi_req_op_o     = req_op_q;
   assign dmi_resp_ready_o = 1'b1;

endmodule

// File: doc/jtag_dtm.md
JTAG_DTM -- requirements
Module: jtag_dtm

Interface
REQ-001 SHALL have parameter IDCODE_VALUE, default 32'h1E20_0A6D, the 32-bit IDCODE shifted out (bit0 SHALL be 1).
REQ-002 SHALL have parameter ABITS, default 7, the DMI address width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth for TCK/TMS/TDI.
REQ-004 SHALL have ports, one per line:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- tck_i, tms_i, tdi_i  in  1 each  JTAG pins from the host; asynchronous.
- tdo_o  out  1  JTAG data out.
- tdo_oe_o  out  1  TDO drive enable.
- dmi_req_valid_o  out  1  DMI request valid.
- dmi_req_ready_i  in  1  DMI request accepted.
- dmi_req_addr_o  out  ABITS  DMI address.
- dmi_req_op_o  out  2  1=read, 2=write.
- dmi_req_data_o  out  32  DMI write data.
- dmi_resp_valid_i  in  1  DMI response valid.
- dmi_resp_ready_o  out  1  tied 1.
- dmi_resp_data_i  in  32  DMI read data.
- dmi_resp_op_i  in  2  0=ok, nonzero=failed.

Function
REQ-005 SHALL pass tck_i, tms_i and tdi_i through SYNC_STAGES flops.
- SHALL detect a TCK rise when the current synchronized TCK is 1 and the previous sample was 0.
- SHALL detect a TCK fall when the current synchronized TCK is 0 and the previous sample was 1.
- Each detected edge SHALL act exactly one clk cycle after detection.
- The bench SHALL hold TCK high and low for at least SYNC_STAGES+2 clk cycles each.
REQ-006 SHALL implement the 16-state IEEE 1149.1 TAP FSM.
- The FSM SHALL advance on TCK rise using the synchronized TMS.
- Five consecutive TMS=1 rises SHALL reach Test-Logic-Reset from any state.
REQ-007 SHALL hold a 5-bit IR.
- Capture-IR SHALL load 5'b00001.
- Shift-IR SHALL shift TDI in at the MSB and shift out the LSB.
- Update-IR SHALL commit the shifted value.
- Opcodes: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI, 0x1F BYPASS; any other opcode SHALL select BYPASS.
REQ-008 Shift-DR SHALL shift the selected DR on TCK rise, LSB first.
- tdo_o and tdo_oe_o SHALL update on TCK fall.
- tdo_oe_o SHALL be 1 only while the FSM is in Shift-IR or Shift-DR.
REQ-009 BYPASS SHALL be a 1-bit register that captures 0.
REQ-010 DTMCS SHALL capture {14'b0, 2'b0, 1'b0, idle=3'd1, dmistat[1:0], abits=ABITS[5:0], version=4'd1}.
- Update-DR with bit16=1 SHALL clear the sticky dmistat.
- Update-DR with bit17=1 SHALL also clear the outstanding flag and drop dmi_req_valid_o.
REQ-011 DMI DR SHALL be ABITS+34 bits: {addr, data[31:0], op[1:0]}.
- Capture-DR SHALL load {last_addr, resp_data, status}.
- status SHALL be 3 if a request is outstanding, otherwise the sticky dmistat.
- A busy capture (status 3) SHALL set sticky dmistat=3.
REQ-012 DMI Update-DR SHALL issue a request when op is 1 or 2, no request is outstanding, and dmistat=0.
- Issuing SHALL assert dmi_req_valid_o the next clk and set the outstanding flag.
- An Update-DR with a request already outstanding SHALL set dmistat=3 and issue nothing.
- op=0 or op=3 SHALL issue nothing.
REQ-013 dmi_req_valid_o and its payload SHALL stay stable until dmi_req_valid_o & dmi_req_ready_i, then deassert the next clk.
REQ-014 On dmi_resp_valid_i, the block SHALL latch resp_data and clear the outstanding flag.
- dmi_resp_op_i != 0 SHALL set sticky dmistat=2, unless dmistat is already nonzero.
REQ-015 If a response and an Update-DR fall in the same clk, the response SHALL be processed first and the new request SHALL be evaluated against the cleared flag.

Reset
REQ-016 reset SHALL force: TAP=Test-Logic-Reset, IR=IDCODE (see REQ-018), dmistat=0, outstanding=0, last_addr=0, resp_data=0.
REQ-017 reset SHALL force all outputs to 0, except dmi_resp_ready_o which stays 1.
- Reset mid-transaction SHALL drop dmi_req_valid_o immediately.
- Test-Logic-Reset SHALL also reload the IR; it SHALL NOT touch DMI state.

Configuration
REQ-018 Macro JTAG_DTM_IDCODE_EN:
- Defined: the IDCODE register SHALL exist, and IR SHALL reset and Test-Logic-Reset to 0x01.
- Undefined: IDCODE SHALL be omitted, IR SHALL reset to 0x1F, and opcode 0x01 SHALL select BYPASS.

Structure
REQ-019 Package jtag_dtm_pkg SHALL hold:
- tap_state_e enum;
- IR opcode constants;
- DMI op and dmistat constants;
- DTMCS version/idle constants.
REQ-020 The TAP FSM SHALL be sub-module jtag_tap_fsm.
- Inputs: clk, reset, tck_rise, tms.
- Outputs: state plus one-hot capture/shift/update strobes.

Verification
REQ-021 TMS=1 for 5 rises, then IR scan 0x01, then 32-bit DR scan -> TDO yields 32'h1E20_0A6D LSB first.
REQ-022 IR=0x1F, shift 8 bits 0xA5 -> TDO returns 0xA5 delayed 1 bit, with a leading 0.
REQ-023 DMI scan {addr=0x10, data=0xDEADBEEF, op=2}, ready_i delayed 3 clk -> valid held 3 clk with stable payload, then drops.
REQ-024 Read op=1 at addr 0x04, resp 0x12345678 with op 0, then DMI scan op=0 -> captured data 0x12345678, status 0.
REQ-025 Second DMI update before the response -> no second request, next capture shows status 3, DTMCS dmistat=3; DTMCS write bit16=1 -> dmistat=0.
REQ-026 Assert reset while dmi_req_valid_o=1 -> valid=0 the same cycle, TAP in Test-Logic-Reset, IR=0x01.
